// File: rtl/reg_file32.sv
// reg_file32 - 32-entry general-purpose register file for the single-cycle datapath.
//
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   rs1_addr/rd1_data   read port 1 (ALU in1), combinational
//   rs2_addr/rd2_data   read port 2 (ALU in2 mux / store data), combinational
//   wr_en/wr_addr/wr_data  write-back port, one write per clock
//   dbg_addr/dbg_data   debug read port, combinational
//   wr_count            16-bit count of committed writes since reset (wraps)
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a committing write forwards wr_data to any read port whose
//               address matches, in the same cycle (write-through)
//   undefined : read ports always return stored contents
module reg_file32 #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                         commit;

  // A write commits only when enabled and not aimed at a hardwired r0.
  // wr_en is tested first so X on wr_addr cannot leak into commit.
  always_comb begin
    commit = 1'b0;
    if (wr_en)
      commit = !((ZERO_REG != 0) && (wr_addr == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem      <= '0;
      wr_count <= '0;
    end else if (commit) begin
      mem[wr_addr] <= wr_data;
      wr_count     <= wr_count + 16'd1;
    end
  end

  // One read path shared by all three ports.
  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = mem[a];
`ifdef REGFILE_BYPASS_EN
    // commit already excludes r0 when hardwired; no forwarding during reset
    if (!rst && commit && (wr_addr == a))
      d = wr_data;
`endif
    if ((ZERO_REG != 0) && (a == '0))
      d = '0;
    return d;
  endfunction

  always_comb begin
    rd1_data = rd_port(rs1_addr);
    rd2_data = rd_port(rs2_addr);
    dbg_data = rd_port(dbg_addr);
  end

endmodule

// File: tb/tb_reg_file32.sv
// tb_reg_file32 - self-checking bench for reg_file32.
// Two instances share all inputs: dz (ZERO_REG=1) and dn (ZERO_REG=0).
// Expected values come from directed constants and from an array-based
// reference model of the register file semantics.
module tb_reg_file32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, wr_en;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, dbg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd1_z, rd2_z, dbg_z, rd1_n, rd2_n, dbg_n;
  logic [15:0] cnt_z, cnt_n;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: [0] = ZERO_REG=1 instance, [1] = ZERO_REG=0 instance
  logic [31:0] m [2][32];
  logic [15:0] mcnt [2];

  always #5 clk = ~clk;

  reg_file32 #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dz (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1_data(rd1_z), .rd2_data(rd2_z), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_z), .wr_count(cnt_z));

  reg_file32 #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dn (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1_data(rd1_n), .rd2_data(rd2_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_n), .wr_count(cnt_n));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected combinational read for instance k (k=0 hardwires r0).
  function automatic logic [31:0] exp_rd(input int k, input logic [4:0] a);
    if (k == 0 && a == 5'd0) return 32'd0;
    if (BYP && !rst && wr_en && wr_addr == a) return wr_data;
    return m[k][a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 32; i++) m[k][i] = 32'd0;
        mcnt[k] = 16'd0;
      end
    end else if (wr_en) begin
      if (wr_addr != 5'd0) begin m[0][wr_addr] = wr_data; mcnt[0]++; end
      m[1][wr_addr] = wr_data; mcnt[1]++;
    end
  endtask

  task automatic check_all();
    chk("rd1_z", rd1_z, exp_rd(0, rs1_addr));
    chk("rd2_z", rd2_z, exp_rd(0, rs2_addr));
    chk("dbg_z", dbg_z, exp_rd(0, dbg_addr));
    chk("cnt_z", {16'd0, cnt_z}, {16'd0, mcnt[0]});
    chk("rd1_n", rd1_n, exp_rd(1, rs1_addr));
    chk("rd2_n", rd2_n, exp_rd(1, rs2_addr));
    chk("dbg_n", dbg_n, exp_rd(1, dbg_addr));
    chk("cnt_n", {16'd0, cnt_n}, {16'd0, mcnt[1]});
  endtask

  // Inputs are set at posedge+1; outputs are checked mid-cycle, then the
  // edge is taken and the model advanced.
  task automatic cyc(input bit do_chk);
    #3;
    if (do_chk) check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0;
  endtask

  typedef struct {
    logic        rst, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs1, rs2;
    logic [31:0] e_rd1_z, e_rd2_z;
    logic [15:0] e_cnt_z;
    logic [31:0] e_rd1_n;
    logic [15:0] e_cnt_n;
  } vec_t;

  vec_t vt [7];

  initial begin
    // row: apply for one cycle, then after the edge read rs1/rs2 with wr_en=0
    vt[0] = '{1'b1, 1'b0, 5'd0, 32'h0,        5'd0, 5'd31, 32'h0,        32'h0,        16'd0, 32'h0,        16'd0};
    vt[1] = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6,  32'hDEADBEEF, 32'h0,        16'd1, 32'hDEADBEEF, 16'd1};
    vt[2] = '{1'b0, 1'b1, 5'd6, 32'h00000007, 5'd5, 5'd6,  32'hDEADBEEF, 32'h7,        16'd2, 32'hDEADBEEF, 16'd2};
    vt[3] = '{1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd6,  32'h0,        32'h7,        16'd2, 32'h12345678, 16'd3};
    vt[4] = '{1'b0, 1'b0, 5'd5, 32'hFFFFFFFF, 5'd5, 5'd6,  32'hDEADBEEF, 32'h7,        16'd2, 32'hDEADBEEF, 16'd3};
    vt[5] = '{1'b0, 1'b1, 5'd3, 32'hAAAA5555, 5'd3, 5'd3,  32'hAAAA5555, 32'hAAAA5555, 16'd3, 32'hAAAA5555, 16'd4};
    vt[6] = '{1'b1, 1'b1, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd5,  32'h0,        32'h0,        16'd0, 32'h0,        16'd0};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 16'hBEEF;
      for (int i = 0; i < 32; i++) m[k][i] = 32'hBAD0BAD0;
    end
    @(posedge clk); model_edge(); #1;

    // reset state: every address on every port reads 0
    idle();
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i); dbg_addr = 5'(i);
      #1;
      chk("rst_rd1", rd1_z | rd1_n, 32'd0);
      chk("rst_rd2", rd2_z | rd2_n, 32'd0);
      chk("rst_dbg", dbg_z | dbg_n, 32'd0);
    end
    chk("rst_cnt", {cnt_z, cnt_n}, 32'd0);

    // directed table
    for (int r = 0; r < 7; r++) begin
      rst = vt[r].rst; wr_en = vt[r].wr_en; wr_addr = vt[r].wr_addr;
      wr_data = vt[r].wr_data; rs1_addr = vt[r].rs1; rs2_addr = vt[r].rs2;
      dbg_addr = vt[r].rs1;
      cyc(1'b1);
      idle(); #1;
      chk($sformatf("vec%0d_rd1_z", r), rd1_z, vt[r].e_rd1_z);
      chk($sformatf("vec%0d_rd2_z", r), rd2_z, vt[r].e_rd2_z);
      chk($sformatf("vec%0d_dbg_z", r), dbg_z, vt[r].e_rd1_z);
      chk($sformatf("vec%0d_cnt_z", r), {16'd0, cnt_z}, {16'd0, vt[r].e_cnt_z});
      chk($sformatf("vec%0d_rd1_n", r), rd1_n, vt[r].e_rd1_n);
      chk($sformatf("vec%0d_cnt_n", r), {16'd0, cnt_n}, {16'd0, vt[r].e_cnt_n});
    end

    // same-cycle hazard on r9
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1; rs1_addr = 5'd9;
    cyc(1'b1);
    wr_data = 32'h2;
    #3;
    chk("hazard_pre", rd1_z, BYP ? 32'h2 : 32'h1);
    @(posedge clk); model_edge(); #1;
    idle(); #1;
    chk("hazard_post", rd1_z, 32'h2);

    // X on write bus while disabled must not corrupt anything
    wr_addr = 'x; wr_data = 'x; rs1_addr = 5'd9; rs2_addr = 5'd5; dbg_addr = 5'd6;
    cyc(1'b1);
    #1;
    chk("xwr_r9", rd1_z, 32'h2);
    chk("xwr_cnt", {16'd0, cnt_z}, {16'd0, mcnt[0]});
    wr_addr = '0; wr_data = '0;

    // bypass must not act during reset
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55; rs1_addr = 5'd9;
    #3;
    chk("rst_nobyp", rd1_z, 32'h2);
    @(posedge clk); model_edge(); #1;
    idle();

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 49) == 0);
      wr_en    = $urandom_range(0, 3) != 0;
      wr_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wr_data  = $urandom;
      rs1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      rs2_addr = ($urandom_range(0, 7) == 0) ? rs1_addr : 5'($urandom);
      dbg_addr = 5'($urandom);
      cyc(1'b1);
    end

    // counter wrap: reset, then 65536 writes to r1
    rst = 1'b1; wr_en = 1'b0;
    cyc(1'b0);
    rst = 1'b0; wr_en = 1'b1; wr_addr = 5'd1;
    for (int i = 0; i < 65536; i++) begin
      wr_data = 32'(i) * 32'd3 + 32'd1;
      @(posedge clk); model_edge(); #1;
    end
    idle(); rs1_addr = 5'd1; rs2_addr = 5'd1; dbg_addr = 5'd1;
    #1;
    chk("wrap_cnt_z", {16'd0, cnt_z}, 32'd0);
    chk("wrap_cnt_n", {16'd0, cnt_n}, 32'd0);
    chk("wrap_r1_z", rd1_z, 32'h0002FFFE);
    chk("wrap_r1_n", rd1_n, 32'h0002FFFE);
    cyc(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
